// File: rtl/nonce_rr_scheduler.sv
// nonce_rr_scheduler: result-side controller for a cluster hub.
// Holds one pending golden nonce per slave. A round-robin arbiter moves
// pending nonces into a shared FIFO, and a handshake FSM feeds the single
// serial transmitter from that FIFO.
// Optional macro NONCE_DEDUP_EN: drops a granted nonce equal to the last
// word written into the FIFO.
//
// Handshake with the transmitter: serial_send is a one-cycle pulse, and
// golden_nonce is valid from that pulse until serial_busy falls. The
// transmitter accepts the word by raising serial_busy and finishes by
// lowering it. If busy never rises within ACK_TIMEOUT cycles the word is
// treated as sent. A new word is offered only while serial_busy is low.
module nonce_rr_scheduler #(
    parameter int SLAVES      = 4,
    parameter int FIFO_LOG2   = 3,
    parameter int ACK_TIMEOUT = 7
) (
    input  logic                   hash_clk,
    input  logic                   reset_n,
    input  logic [SLAVES-1:0]      new_nonces,
    input  logic [SLAVES*32-1:0]   slave_nonces,
    input  logic                   serial_busy,
    output logic                   serial_send,
    output logic [31:0]            golden_nonce,
    output logic [FIFO_LOG2:0]     fifo_level,
    output logic [15:0]            dropped_count,
    output logic [1:0]             state_dbg
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int PW    = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int TW    = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    logic [SLAVES-1:0]  pend;
    logic [31:0]        pend_nonce [SLAVES];
    logic [PW-1:0]      rr_ptr;
    logic [31:0]        mem [DEPTH];
    logic [FIFO_LOG2:0] wr_ptr;
    logic [FIFO_LOG2:0] rd_ptr;
    state_t             state;
    state_t             state_nx;
    logic [TW-1:0]      timer;
    logic [TW-1:0]      timer_nx;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_wr;
    logic               fifo_rd;
    logic               grant_vld;
    logic [PW-1:0]      grant_idx;
    logic [PW-1:0]      cand;
    logic [31:0]        grant_word;
    logic [SLAVES-1:0]  drop_vec;
    logic [16:0]        drop_sum;

    // Full/empty come from registered pointers only, so a pop never
    // unblocks a push in the same cycle.
    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_LOG2] != rd_ptr[FIFO_LOG2]) &&
                        (wr_ptr[FIFO_LOG2-1:0] == rd_ptr[FIFO_LOG2-1:0]);
    assign grant_word = pend_nonce[grant_idx];
    assign state_dbg  = state;

    // Round-robin search from rr_ptr for the first pending slave.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!fifo_full) begin
            for (int k = 0; k < SLAVES; k++) begin
                cand = PW'((int'(rr_ptr) + k) % SLAVES);
                if (!grant_vld && pend[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

`ifdef NONCE_DEDUP_EN
    logic [31:0] last_enq;
    logic        last_vld;

    assign fifo_wr = grant_vld && !(last_vld && (grant_word == last_enq));

    // Remember the last word written into the FIFO for duplicate filtering.
    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            last_enq <= '0;
            last_vld <= 1'b0;
        end else if (fifo_wr) begin
            last_enq <= grant_word;
            last_vld <= 1'b1;
        end
    end
`else
    assign fifo_wr = grant_vld;
`endif

    // A capture onto an occupied slot that is not being drained is a drop;
    // several slaves can drop in one cycle, so the count is summed.
    always_comb begin
        drop_vec = '0;
        drop_sum = {1'b0, dropped_count};
        for (int i = 0; i < SLAVES; i++) begin
            drop_vec[i] = new_nonces[i] && pend[i] &&
                          !(grant_vld && (grant_idx == PW'(i)));
            drop_sum    = drop_sum + {16'd0, drop_vec[i]};
        end
    end

    // Per-slave capture, grant clearing, RR pointer and drop counter.
    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            pend          <= '0;
            rr_ptr        <= '0;
            dropped_count <= '0;
        end else begin
            for (int i = 0; i < SLAVES; i++) begin
                if (new_nonces[i]) begin
                    pend[i]       <= 1'b1;
                    pend_nonce[i] <= slave_nonces[i*32 +: 32];
                end else if (grant_vld && (grant_idx == PW'(i))) begin
                    pend[i] <= 1'b0;
                end
            end
            if (grant_vld) begin
                rr_ptr <= (grant_idx == PW'(SLAVES - 1)) ? '0 : grant_idx + PW'(1);
            end
            dropped_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // FIFO storage; contents need no reset since the pointers gate them.
    always_ff @(posedge hash_clk) begin
        if (fifo_wr) begin
            mem[wr_ptr[FIFO_LOG2-1:0]] <= grant_word;
        end
    end

    // FIFO pointers.
    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Transmit FSM next state: offer a word, wait for acceptance, wait for completion.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        fifo_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !serial_busy) begin
                    fifo_rd  = 1'b1;
                    state_nx = WAIT_ACK;
                    timer_nx = '0;
                end
            end
            WAIT_ACK: begin
                if (serial_busy) begin
                    state_nx = WAIT_DONE;
                end else begin
                    timer_nx = timer + TW'(1);
                    if (timer_nx == TW'(ACK_TIMEOUT)) state_nx = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!serial_busy) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Transmit FSM registers; golden_nonce changes only on a pop.
    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            timer        <= '0;
            serial_send  <= 1'b0;
            golden_nonce <= '0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            serial_send <= fifo_rd;
            if (fifo_rd) golden_nonce <= mem[rd_ptr[FIFO_LOG2-1:0]];
        end
    end

endmodule
